// File: rtl/pspin_ctrl_axil_master.sv
// Command/response stream to single AXI-Lite transactions, one outstanding at a time.
// Define PSPIN_CTRL_TIMEOUT_EN to build the response timeout and late-beat drain logic.

module pspin_ctrl_axil_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  input  logic [STRB_WIDTH-1:0] cmd_wstrb,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_REQ = 3'd1,
    WR_RSP = 3'd2,
    RD_REQ = 3'd3,
    RD_RSP = 3'd4,
    RESP   = 3'd5
  } state_t;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("pspin_ctrl_axil_master: TIMEOUT_CYCLES must be >= 2");
  end

  state_t                state_q, state_d;
  logic                  write_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;

  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic drain_q, drain_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic bready_q, bready_d, rready_q, rready_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic accept, aw_hs, w_hs, ar_hs, b_hs, r_hs, beat, expired;

  assign accept = cmd_valid && cmd_ready_q;
  assign aw_hs  = awvalid_q && m_axil_awready;
  assign w_hs   = wvalid_q && m_axil_wready;
  assign ar_hs  = arvalid_q && m_axil_arready;
  assign b_hs   = bready_q && m_axil_bvalid;
  assign r_hs   = rready_q && m_axil_rvalid;
  assign beat   = write_q ? b_hs : r_hs;

`ifdef PSPIN_CTRL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic             in_rsp;

  assign in_rsp  = (state_q == WR_RSP) || (state_q == RD_RSP);
  assign expired = in_rsp && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      tmo_cnt_q <= '0;
    else if (in_rsp) tmo_cnt_q <= tmo_cnt_q + 1'b1;
    else             tmo_cnt_q <= '0;
  end
`else
  assign expired = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    drain_d       = drain_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = cmd_write ? WR_REQ : RD_REQ;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_REQ: begin
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_done_d && w_done_d) state_d = WR_RSP;
      end
      RD_REQ: begin
        if (ar_hs) state_d = RD_RSP;
      end
      WR_RSP, RD_RSP: begin
        // A beat in the expiry cycle wins over the timeout.
        if (beat) begin
          state_d       = RESP;
          rsp_rdata_d   = write_q ? '0 : m_axil_rdata;
          rsp_resp_d    = write_q ? m_axil_bresp : m_axil_rresp;
          rsp_timeout_d = 1'b0;
        end else if (expired) begin
          state_d       = RESP;
          rsp_rdata_d   = '1;
          rsp_resp_d    = 2'b10;
          rsp_timeout_d = 1'b1;
          drain_d       = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The late beat of a timed-out transaction is swallowed here.
    if (drain_q && beat) drain_d = 1'b0;

    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    arvalid_d   = (state_d == RD_REQ);
    bready_d    = write_q && (((state_q == WR_RSP) && (state_d == WR_RSP)) || drain_d);
    rready_d    = !write_q && (((state_q == RD_RSP) && (state_d == RD_RSP)) || drain_d);
    cmd_ready_d = (state_d == IDLE) && !drain_d;
    rsp_valid_d = (state_d == RESP);
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      drain_q       <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      bready_q      <= 1'b0;
      rready_q      <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      drain_q       <= drain_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      arvalid_q     <= arvalid_d;
      bready_q      <= bready_d;
      rready_q      <= rready_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else if (accept) begin
      write_q <= cmd_write;
      addr_q  <= cmd_addr;
      wdata_q <= cmd_wdata;
      wstrb_q <= cmd_wstrb;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;

  assign m_axil_awaddr  = addr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = addr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_pspin_ctrl_axil_master.sv
// Directed self-checking bench for pspin_ctrl_axil_master; the slave side is driven by hand.
// The timeout scenario is built only when PSPIN_CTRL_TIMEOUT_EN is defined.

module tb_pspin_ctrl_axil_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int t_acc    = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;

  always #5 clk = ~clk;

  pspin_ctrl_axil_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  always @(posedge clk) begin
    if (rst_n) begin
      if (awvalid && awready) aw_cnt <= aw_cnt + 1;
      if (wvalid && wready)   w_cnt  <= w_cnt + 1;
      if (bvalid && bready)   b_cnt  <= b_cnt + 1;
      if (arvalid && arready) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready)   r_cnt  <= r_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_cmd(input logic wr, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb);
    int waited = 0;
    while (!cmd_ready && waited < 64) begin
      tick();
      waited++;
    end
    check("cmd_ready_seen", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    cmd_wstrb = strb;
    tick();
    t_acc     = cyc - 1;
    cmd_valid = 1'b0;
  endtask

  task automatic slave_b(input logic [1:0] resp);
    logic done = 1'b0;
    bvalid = 1'b1;
    bresp  = resp;
    for (int i = 0; i < 64 && !done; i++) begin
      done = bready;
      tick();
    end
    bvalid = 1'b0;
    bresp  = 2'b00;
    check("b_handshake", done, 1'b1);
  endtask

  task automatic slave_r(input logic [31:0] data, input logic [1:0] resp);
    logic done = 1'b0;
    rvalid = 1'b1;
    rdata  = data;
    rresp  = resp;
    for (int i = 0; i < 64 && !done; i++) begin
      done = rready;
      tick();
    end
    rvalid = 1'b0;
    rdata  = '0;
    rresp  = 2'b00;
    check("r_handshake", done, 1'b1);
  endtask

  task automatic wait_rsp();
    int waited = 0;
    while (!rsp_valid && waited < 64) begin
      tick();
      waited++;
    end
    check("rsp_valid_seen", rsp_valid, 1'b1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int b0, aw0, w0, r0;
    logic saw_rsp;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    awready = 1; wready = 1; arready = 1;
    bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_axi_handshake", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_rsp", {rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}, 36'h0);
    #3 rst_n = 1'b1;
    tick();
    check("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Write 0x4 <= 0x1, always-ready slave
    send_cmd(1'b1, 32'h4, 32'h1, 4'hF);
    check("wr_valids", {awvalid, wvalid, cmd_ready}, 3'b110);
    check("wr_aw_w", {awaddr, wdata, wstrb, awprot}, {32'h4, 32'h1, 4'hF, 3'b000});
    tick();
    check("wr_valids_drop", {awvalid, wvalid}, 2'b00);
    slave_b(2'b00);
    wait_rsp();
    check("wr_latency", cyc - t_acc, 4);
    check("wr_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, 35'h0);
    consume();
    check("b2b_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    check("wr_beats", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0]}, 24'h010101);

    // Read 0x100 with arready stalled for 5 cycles
    arready = 1'b0;
    send_cmd(1'b0, 32'h100, 32'h0, 4'h0);
    check("rd_araddr", {araddr, arprot}, {32'h100, 3'b000});
    for (int i = 0; i < 5; i++) begin
      check("rd_arvalid_held", arvalid, 1'b1);
      tick();
    end
    check("rd_arvalid_held", arvalid, 1'b1);
    arready = 1'b1;
    tick();
    check("rd_arvalid_drop", arvalid, 1'b0);
    slave_r(32'h3, 2'b00);
    wait_rsp();
    check("rd_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h3});
    consume();

    // Split AW/W: awready delayed 3 cycles, wready immediate
    awready = 1'b0;
    b0 = b_cnt; aw0 = aw_cnt; w0 = w_cnt;
    send_cmd(1'b1, 32'h8, 32'hA5A5_0000, 4'hC);
    check("split_c1", {awvalid, wvalid}, 2'b11);
    tick();
    check("split_c2", {awvalid, wvalid}, 2'b10);
    tick();
    check("split_c3", {awvalid, wvalid}, 2'b10);
    tick();
    check("split_c4", {awvalid, wvalid}, 2'b10);
    awready = 1'b1;
    tick();
    check("split_c5", {awvalid, wvalid}, 2'b00);
    slave_b(2'b00);
    wait_rsp();
    check("split_rsp", {rsp_timeout, rsp_resp}, 3'b000);
    consume();
    tick();
    check("split_beats", {aw_cnt - aw0, w_cnt - w0, b_cnt - b0}, {32'd1, 32'd1, 32'd1});

    // Backpressure on the response stream
    send_cmd(1'b0, 32'h40, 32'h0, 4'h0);
    tick();
    slave_r(32'h1234, 2'b00);
    wait_rsp();
    check("rd_latency", cyc - t_acc, 4);
    for (int i = 0; i < 6; i++) begin
      check("bp_hold", {rsp_valid, cmd_ready, rsp_timeout, rsp_resp, rsp_rdata},
            {1'b1, 1'b0, 1'b0, 2'b00, 32'h1234});
      tick();
    end
    consume();
    check("bp_released", {rsp_valid, cmd_ready}, 2'b01);

    // Slave error response
    send_cmd(1'b0, 32'h2000, 32'h0, 4'h0);
    tick();
    slave_r(32'h0, 2'b10);
    wait_rsp();
    check("err_rsp", {rsp_timeout, rsp_resp}, 3'b010);
    consume();

`ifdef PSPIN_CTRL_TIMEOUT_EN
    // R withheld: timeout after 16 cycles in RD_RSP, late beat at cycle 30 drained
    r0 = r_cnt;
    send_cmd(1'b0, 32'h300, 32'h0, 4'h0);
    wait_rsp();
    check("tmo_latency", cyc - t_acc, 18);
    check("tmo_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b1, 2'b10, 32'hFFFF_FFFF});
    check("tmo_rready_held", rready, 1'b1);
    consume();
    while (cyc - t_acc < 30) begin
      check("tmo_cmd_blocked", {cmd_ready, rready}, 2'b01);
      tick();
    end
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    check("tmo_cmd_blocked_c30", cmd_ready, 1'b0);
    tick();
    rvalid = 1'b0;
    rdata  = '0;
    check("tmo_drained", {cmd_ready, rready, rsp_valid}, 3'b100);
    check("tmo_late_beat", r_cnt - r0, 1);
    send_cmd(1'b0, 32'h4, 32'h0, 4'h0);
    tick();
    slave_r(32'h77, 2'b00);
    wait_rsp();
    check("post_tmo_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h77});
    consume();
`else
    // Without the timeout the block waits indefinitely for R
    r0 = r_cnt;
    saw_rsp = 1'b0;
    send_cmd(1'b0, 32'h300, 32'h0, 4'h0);
    for (int i = 0; i < 40; i++) begin
      saw_rsp = saw_rsp | rsp_valid;
      tick();
    end
    check("no_tmo_wait", {saw_rsp, rready}, 2'b01);
    slave_r(32'h55, 2'b00);
    wait_rsp();
    check("no_tmo_rsp", {rsp_timeout, rsp_resp, rsp_rdata}, {1'b0, 2'b00, 32'h55});
    check("no_tmo_beats", r_cnt - r0, 1);
    consume();
`endif

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
